// File: rtl/msrv32_instruction_mux.sv
// msrv32_instruction_mux
// Front end of the decode stage. It registers either the fetched instruction
// or a canonical NOP (on flush), then splits the registered word into the
// RV32 fields that the decoder, the register file and the immediate generator
// use.
//
// Ports:
//   ms_riscv32_mp_clk_in   - system clock, rising edge
//   ms_riscv32_mp_rst_in   - asynchronous reset, active high; loads NOP_INSTR
//   flush_in               - 1 = replace the incoming word with NOP_INSTR
//   ms_risc32_mp__instr_in - fetched 32-bit instruction
//   opcode_out   [6:0]     - instr[6:0]
//   rdaddr_out   [4:0]     - instr[11:7]
//   funct3_out   [2:0]     - instr[14:12]
//   rs1addr_out  [4:0]     - instr[19:15]
//   rs2addr_out  [4:0]     - instr[24:20]
//   funct7_out   [6:0]     - instr[31:25]
//   csr_addr_out [11:0]    - instr[31:20]
//   instr_out    [31:7]    - instr[31:7], source bits for the immediate generator
module msrv32_instruction_mux #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        flush_in,
  input  logic [31:0] ms_risc32_mp__instr_in,
  output logic [6:0]  opcode_out,
  output logic [4:0]  rdaddr_out,
  output logic [2:0]  funct3_out,
  output logic [4:0]  rs1addr_out,
  output logic [4:0]  rs2addr_out,
  output logic [6:0]  funct7_out,
  output logic [11:0] csr_addr_out,
  output logic [31:7] instr_out
);

  logic [31:0] instr_d;
  logic [31:0] instr_q;

  // Flush takes priority, so the fetched word is ignored (it may be X) while
  // flush_in is high.
  always_comb begin
    instr_d = ms_risc32_mp__instr_in;
    if (flush_in) begin
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      instr_q <= NOP_INSTR;
    end else begin
      instr_q <= instr_d;
    end
  end

  // Every output is a slice of the register, so no input reaches an output
  // combinationally. The CSR field overlaps funct7/rs2 on purpose.
  assign opcode_out   = instr_q[6:0];
  assign rdaddr_out   = instr_q[11:7];
  assign funct3_out   = instr_q[14:12];
  assign rs1addr_out  = instr_q[19:15];
  assign rs2addr_out  = instr_q[24:20];
  assign funct7_out   = instr_q[31:25];
  assign csr_addr_out = instr_q[31:20];
  assign instr_out    = instr_q[31:7];

endmodule

// File: tb/tb_msrv32_instruction_mux.sv
module tb_msrv32_instruction_mux;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] instr_in;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] csr;
  logic [31:7] imm_src;

  int checks;
  int failures;

  // All outputs packed in port order: opcode, rd, funct3, rs1, rs2, funct7, csr, instr_out.
  logic [68:0] all_out;
  assign all_out = {opcode, rd, funct3, rs1, rs2, funct7, csr, imm_src};

  // Field values worked out by hand from each test word.
  localparam logic [68:0] EXP_NOP  = {7'h13, 5'h00, 3'h0, 5'h00, 5'h00, 7'h00, 12'h000, 25'h0000000};
  localparam logic [68:0] EXP_1234 = {7'h78, 5'h0C, 3'h5, 5'h08, 5'h03, 7'h09, 12'h123, 25'h02468AC};
  localparam logic [68:0] EXP_ABCD = {7'h01, 5'h1E, 3'h6, 5'h1B, 5'h1C, 7'h55, 12'hABC, 25'h1579BDE};

  msrv32_instruction_mux dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_in   (rst),
    .flush_in               (flush),
    .ms_risc32_mp__instr_in (instr_in),
    .opcode_out             (opcode),
    .rdaddr_out             (rd),
    .funct3_out             (funct3),
    .rs1addr_out            (rs1),
    .rs2addr_out            (rs2),
    .funct7_out             (funct7),
    .csr_addr_out           (csr),
    .instr_out              (imm_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge, then let the outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    instr_in = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (all_out !== EXP_NOP) begin
      failures++;
      $display("FAIL reset_no_edge: got %h expected %h", all_out, EXP_NOP);
    end
    checks++;
    if (opcode !== 7'h13) begin
      failures++;
      $display("FAIL reset_opcode: got %h expected 13", opcode);
    end
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b1;
    step();
    checks++;
    if (all_out !== EXP_NOP) begin
      failures++;
      $display("FAIL reset_release_flush: got %h expected %h", all_out, EXP_NOP);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    flush = 1'b0;
    instr_in = 32'h1234_5678;
    #2;
    checks++;
    if (all_out !== EXP_NOP) begin
      failures++;
      $display("FAIL capture_before_edge: got %h expected %h", all_out, EXP_NOP);
    end
    step();
    checks++;
    if (all_out !== EXP_1234) begin
      failures++;
      $display("FAIL capture_1234: got %h expected %h", all_out, EXP_1234);
    end
    checks++;
    if (csr !== 12'h123) begin
      failures++;
      $display("FAIL capture_csr: got %h expected 123", csr);
    end
    checks++;
    if (imm_src !== 25'h02468AC) begin
      failures++;
      $display("FAIL capture_instr_out: got %h expected 02468ac", imm_src);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1;
    instr_in = 32'h1234_5678;
    step();
    checks++;
    if (all_out !== EXP_NOP) begin
      failures++;
      $display("FAIL flush_first: got %h expected %h", all_out, EXP_NOP);
    end
    // The input word is don't-care during flush, including X.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_in = (i == 1) ? 32'hxxxx_xxxx : 32'hABCD_EF01;
      step();
      checks++;
      if (all_out !== EXP_NOP) begin
        failures++;
        $display("FAIL flush_hold_%0d: got %h expected %h", i, all_out, EXP_NOP);
      end
    end
  endtask

  task automatic test_resume();
    @(negedge clk);
    flush = 1'b0;
    instr_in = 32'hABCD_EF01;
    step();
    checks++;
    if (all_out !== EXP_ABCD) begin
      failures++;
      $display("FAIL resume_abcd: got %h expected %h", all_out, EXP_ABCD);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [68:0] exps [3];
    words[0] = 32'h1234_5678; exps[0] = EXP_1234;
    words[1] = 32'hABCD_EF01; exps[1] = EXP_ABCD;
    words[2] = 32'h0000_0013; exps[2] = EXP_NOP;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_in = words[i];
      step();
      checks++;
      if (all_out !== exps[i]) begin
        failures++;
        $display("FAIL b2b_%0d: got %h expected %h", i, all_out, exps[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    flush = 1'b0;
    instr_in = 32'hABCD_EF01;
    step();
    checks++;
    if (all_out !== EXP_ABCD) begin
      failures++;
      $display("FAIL areset_pre: got %h expected %h", all_out, EXP_ABCD);
    end
    // Assert reset between edges; the outputs must drop without a clock.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== EXP_NOP) begin
      failures++;
      $display("FAIL areset_immediate: got %h expected %h", all_out, EXP_NOP);
    end
    // Flush and reset together: still NOP.
    flush = 1'b1;
    step();
    checks++;
    if (all_out !== EXP_NOP) begin
      failures++;
      $display("FAIL areset_with_flush: got %h expected %h", all_out, EXP_NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    instr_in = 32'h1234_5678;
    step();
    checks++;
    if (all_out !== EXP_1234) begin
      failures++;
      $display("FAIL areset_release_capture: got %h expected %h", all_out, EXP_1234);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_capture();
    test_flush();
    test_resume();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
